// File: rtl/mcu_fifo_sched.sv
// rtl/mcu_fifo_sched.sv - MCU-order scheduler merging Y/Cb/Cr coefficient FIFOs into one stream
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   cfg_ny, cfg_gray           Y blocks per MCU (clamped to 1..4), Y-only MCU select
//   flush                      synchronous abort of the current MCU
//   {y,cb,cr}_empty/_dout      show-ahead FIFO status and head data
//   {y,cb,cr}_rd               FIFO pop strobes (equal to a transfer from that FIFO)
//   out_valid/out_ready        output handshake
//   out_data, out_comp         coefficient and component tag (0=Y, 1=Cb, 2=Cr)
//   out_blk_last, out_mcu_last block / MCU end markers
//   mcu_cnt                    completed MCU count, wraps
module mcu_fifo_sched #(
    parameter int DW      = 12,
    parameter int BLK_LEN = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    cfg_ny,
    input  logic          cfg_gray,
    input  logic          flush,
    input  logic          y_empty,
    input  logic          cb_empty,
    input  logic          cr_empty,
    input  logic [DW-1:0] y_dout,
    input  logic [DW-1:0] cb_dout,
    input  logic [DW-1:0] cr_dout,
    output logic          y_rd,
    output logic          cb_rd,
    output logic          cr_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_comp,
    output logic          out_blk_last,
    output logic          out_mcu_last,
    output logic [15:0]   mcu_cnt
);

    localparam int SW = $clog2(BLK_LEN);
    localparam logic [SW-1:0] SMP_LAST = SW'(BLK_LEN - 1);

    // State encoding doubles as the component tag.
    localparam logic [1:0] S_Y  = 2'd0;
    localparam logic [1:0] S_CB = 2'd1;
    localparam logic [1:0] S_CR = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] smp_q, smp_d;
    logic [1:0]    blk_q, blk_d;
    logic [2:0]    ny_r_q, ny_r_d;
    logic          gray_r_q, gray_r_d;
    logic [15:0]   mcu_cnt_q, mcu_cnt_d;

    logic          at_start;
    logic [2:0]    ny_clamped;
    logic [2:0]    ny_eff;
    logic [2:0]    ny_m1;
    logic          gray_eff;
    logic          src_empty;
    logic [DW-1:0] src_data;
    logic          xfer;
    logic          blk_end;
    logic          y_last_blk;
    logic          mcu_end;

    always_comb begin
        if (cfg_ny == 3'd0)      ny_clamped = 3'd1;
        else if (cfg_ny > 3'd4)  ny_clamped = 3'd4;
        else                     ny_clamped = cfg_ny;
    end

    // At the MCU start position nothing has been committed yet, so the live
    // config governs; from the first transfer on, the latched copy does.
    assign at_start   = (state_q == S_Y) && (blk_q == 2'd0) && (smp_q == '0);
    assign ny_eff     = at_start ? ny_clamped : ny_r_q;
    assign gray_eff   = at_start ? cfg_gray   : gray_r_q;
    assign ny_m1      = ny_eff - 3'd1;
    assign y_last_blk = (blk_q == ny_m1[1:0]);

    always_comb begin
        src_empty = y_empty;
        src_data  = y_dout;
        case (state_q)
            S_CB: begin
                src_empty = cb_empty;
                src_data  = cb_dout;
            end
            S_CR: begin
                src_empty = cr_empty;
                src_data  = cr_dout;
            end
            default: begin
                src_empty = y_empty;
                src_data  = y_dout;
            end
        endcase
    end

    assign out_valid    = !rst && !src_empty && !flush;
    assign xfer         = out_valid && out_ready;
    assign out_data     = src_data;
    assign out_comp     = state_q;
    assign y_rd         = xfer && (state_q == S_Y);
    assign cb_rd        = xfer && (state_q == S_CB);
    assign cr_rd        = xfer && (state_q == S_CR);
    assign blk_end      = (smp_q == SMP_LAST);
    assign mcu_end      = (state_q == S_CR) || ((state_q == S_Y) && gray_eff && y_last_blk);
    assign out_blk_last = out_valid && blk_end;
    assign out_mcu_last = out_blk_last && mcu_end;
    assign mcu_cnt      = mcu_cnt_q;

    always_comb begin
        state_d   = state_q;
        smp_d     = smp_q;
        blk_d     = blk_q;
        ny_r_d    = ny_r_q;
        gray_r_d  = gray_r_q;
        mcu_cnt_d = mcu_cnt_q;
        if (flush) begin
            state_d = S_Y;
            smp_d   = '0;
            blk_d   = 2'd0;
        end else if (xfer) begin
            // BLK_LEN is a power of two, so the natural wrap returns smp to 0.
            smp_d = smp_q + 1'b1;
            if (at_start) begin
                ny_r_d   = ny_clamped;
                gray_r_d = cfg_gray;
            end
            if (blk_end) begin
                case (state_q)
                    S_Y: begin
                        if (y_last_blk) begin
                            blk_d   = 2'd0;
                            state_d = gray_eff ? S_Y : S_CB;
                        end else begin
                            blk_d = blk_q + 2'd1;
                        end
                    end
                    S_CB:    state_d = S_CR;
                    default: state_d = S_Y;
                endcase
                if (mcu_end) mcu_cnt_d = mcu_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_Y;
            smp_q     <= '0;
            blk_q     <= 2'd0;
            ny_r_q    <= 3'd1;
            gray_r_q  <= 1'b0;
            mcu_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            smp_q     <= smp_d;
            blk_q     <= blk_d;
            ny_r_q    <= ny_r_d;
            gray_r_q  <= gray_r_d;
            mcu_cnt_q <= mcu_cnt_d;
        end
    end

endmodule

// File: tb/tb_mcu_fifo_sched.sv
// tb/tb_mcu_fifo_sched.sv - directed bench for mcu_fifo_sched with show-ahead FIFO models
module tb_mcu_fifo_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cfg_ny;
    logic        cfg_gray;
    logic        flush;
    logic        y_empty, cb_empty, cr_empty;
    logic [11:0] y_dout, cb_dout, cr_dout;
    logic        y_rd, cb_rd, cr_rd;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [1:0]  out_comp;
    logic        out_blk_last;
    logic        out_mcu_last;
    logic [15:0] mcu_cnt;

    int checks   = 0;
    int failures = 0;

    logic [11:0] yq[$];
    logic [11:0] cbq[$];
    logic [11:0] crq[$];

    mcu_fifo_sched #(.DW(12), .BLK_LEN(64)) dut (
        .clk(clk), .rst(rst), .cfg_ny(cfg_ny), .cfg_gray(cfg_gray), .flush(flush),
        .y_empty(y_empty), .cb_empty(cb_empty), .cr_empty(cr_empty),
        .y_dout(y_dout), .cb_dout(cb_dout), .cr_dout(cr_dout),
        .y_rd(y_rd), .cb_rd(cb_rd), .cr_rd(cr_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_comp(out_comp), .out_blk_last(out_blk_last), .out_mcu_last(out_mcu_last),
        .mcu_cnt(mcu_cnt)
    );

    always #5 clk = ~clk;

    task automatic refresh();
        y_empty  = (yq.size() == 0);
        cb_empty = (cbq.size() == 0);
        cr_empty = (crq.size() == 0);
        y_dout   = y_empty  ? 12'h000 : yq[0];
        cb_dout  = cb_empty ? 12'h000 : cbq[0];
        cr_dout  = cr_empty ? 12'h000 : crq[0];
    endtask

    // Called at the negedge after checks: pops whatever the DUT strobed.
    task automatic tick();
        logic yr, br, rr;
        yr = y_rd; br = cb_rd; rr = cr_rd;
        @(posedge clk);
        #1;
        if (yr && yq.size() > 0)  void'(yq.pop_front());
        if (br && cbq.size() > 0) void'(cbq.pop_front());
        if (rr && crq.size() > 0) void'(crq.pop_front());
        refresh();
    endtask

    task automatic fill(input int ny_n, input int cb_n, input int cr_n);
        for (int i = 0; i < ny_n; i++) yq.push_back(12'(i));
        for (int i = 0; i < cb_n; i++) cbq.push_back(12'(12'h400 + i));
        for (int i = 0; i < cr_n; i++) crq.push_back(12'(12'h800 + i));
        refresh();
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; cfg_ny = 3'd1; cfg_gray = 1'b0;
        yq.delete(); cbq.delete(); crq.delete();
        refresh();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; cfg_ny = 3'd4; cfg_gray = 1'b0;
        yq.delete(); cbq.delete(); crq.delete();
        fill(8, 8, 8);
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if ({y_rd, cb_rd, cr_rd} !== 3'b000) begin failures++; $display("FAIL reset_rd got=%b exp=000", {y_rd, cb_rd, cr_rd}); end
        checks++; if (out_comp !== 2'd0) begin failures++; $display("FAIL reset_comp got=%0d exp=0", out_comp); end
        checks++; if ({out_blk_last, out_mcu_last} !== 2'b00) begin failures++; $display("FAIL reset_last got=%b exp=00", {out_blk_last, out_mcu_last}); end
        checks++; if (mcu_cnt !== 16'd0) begin failures++; $display("FAIL reset_mcu_cnt got=%0d exp=0", mcu_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_mcu_sequence(input logic [2:0] ny_cfg, input logic gray, input int nyb);
        int total;
        logic [11:0] ed;
        logic [1:0]  ec;
        do_reset();
        cfg_ny = ny_cfg; cfg_gray = gray;
        fill(nyb * 64, gray ? 0 : 64, gray ? 0 : 64);
        total = (nyb + (gray ? 0 : 2)) * 64;
        for (int i = 0; i < total; i++) begin
            if (i < nyb * 64)            begin ec = 2'd0; ed = 12'(i); end
            else if (i < (nyb + 1) * 64) begin ec = 2'd1; ed = 12'(12'h400 + i - nyb * 64); end
            else                         begin ec = 2'd2; ed = 12'(12'h800 + i - (nyb + 1) * 64); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL seq_valid ny=%0d i=%0d got=%b exp=1", ny_cfg, i, out_valid); end
            checks++; if (out_comp !== ec) begin failures++; $display("FAIL seq_comp ny=%0d i=%0d got=%0d exp=%0d", ny_cfg, i, out_comp, ec); end
            checks++; if (out_data !== ed) begin failures++; $display("FAIL seq_data ny=%0d i=%0d got=%h exp=%h", ny_cfg, i, out_data, ed); end
            checks++; if ({cr_rd, cb_rd, y_rd} !== (3'b001 << ec)) begin failures++; $display("FAIL seq_rd ny=%0d i=%0d got=%b exp=%b", ny_cfg, i, {cr_rd, cb_rd, y_rd}, 3'b001 << ec); end
            checks++; if (out_blk_last !== (i % 64 == 63)) begin failures++; $display("FAIL seq_blk_last ny=%0d i=%0d got=%b", ny_cfg, i, out_blk_last); end
            checks++; if (out_mcu_last !== (i == total - 1)) begin failures++; $display("FAIL seq_mcu_last ny=%0d i=%0d got=%b", ny_cfg, i, out_mcu_last); end
            tick();
        end
        @(negedge clk);
        checks++; if (mcu_cnt !== 16'd1) begin failures++; $display("FAIL seq_mcu_cnt ny=%0d got=%0d exp=1", ny_cfg, mcu_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL seq_drained ny=%0d got=%b exp=0", ny_cfg, out_valid); end
    endtask

    task automatic test_gray_cfg_latch();
        do_reset();
        cfg_ny = 3'd2; cfg_gray = 1'b1;
        fill(384, 4, 4);
        for (int i = 0; i < 384; i++) begin
            if (i == 5) cfg_ny = 3'd4;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_comp !== 2'd0) begin failures++; $display("FAIL gray_valid_comp i=%0d got=%b/%0d exp=1/0", i, out_valid, out_comp); end
            checks++; if ({cb_rd, cr_rd} !== 2'b00) begin failures++; $display("FAIL gray_chroma_rd i=%0d got=%b exp=00", i, {cb_rd, cr_rd}); end
            checks++; if (out_blk_last !== (i % 64 == 63)) begin failures++; $display("FAIL gray_blk_last i=%0d got=%b", i, out_blk_last); end
            checks++; if (out_mcu_last !== (i == 127 || i == 383)) begin failures++; $display("FAIL gray_mcu_last i=%0d got=%b", i, out_mcu_last); end
            tick();
        end
        @(negedge clk);
        checks++; if (mcu_cnt !== 16'd2) begin failures++; $display("FAIL gray_mcu_cnt got=%0d exp=2", mcu_cnt); end
    endtask

    task automatic test_cb_stall();
        do_reset();
        cfg_ny = 3'd1; cfg_gray = 1'b0;
        fill(128, 0, 64);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || y_rd !== 1'b0) begin failures++; $display("FAIL stall_cb i=%0d got valid=%b y_rd=%b exp=0/0", i, out_valid, y_rd); end
            checks++; if (out_comp !== 2'd1) begin failures++; $display("FAIL stall_comp i=%0d got=%0d exp=1", i, out_comp); end
            tick();
        end
        cbq.push_back(12'h4AA);
        refresh();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || cb_rd !== 1'b1) begin failures++; $display("FAIL stall_one_xfer got valid=%b cb_rd=%b exp=1/1", out_valid, cb_rd); end
        checks++; if (out_comp !== 2'd1 || out_data !== 12'h4AA) begin failures++; $display("FAIL stall_one_tag got comp=%0d data=%h exp=1/4aa", out_comp, out_data); end
        tick();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || y_rd !== 1'b0) begin failures++; $display("FAIL stall_after got valid=%b y_rd=%b exp=0/0", out_valid, y_rd); end
    endtask

    task automatic test_flush();
        logic [15:0] cnt0;
        do_reset();
        cfg_ny = 3'd1; cfg_gray = 1'b0;
        fill(128, 15, 0);
        for (int i = 0; i < 74; i++) begin
            @(negedge clk);
            tick();
        end
        cnt0 = mcu_cnt;
        flush = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || cb_rd !== 1'b0) begin failures++; $display("FAIL flush_block got valid=%b cb_rd=%b exp=0/0", out_valid, cb_rd); end
        tick();
        flush = 1'b0;
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_comp !== 2'd0) begin failures++; $display("FAIL flush_resume j=%0d got valid=%b comp=%0d exp=1/0", j, out_valid, out_comp); end
            checks++; if (out_blk_last !== (j == 63)) begin failures++; $display("FAIL flush_smp j=%0d blk_last got=%b", j, out_blk_last); end
            if (j == 0) begin
                checks++; if (out_data !== 12'd64) begin failures++; $display("FAIL flush_data got=%h exp=040", out_data); end
            end
            tick();
        end
        checks++; if (mcu_cnt !== cnt0 || cnt0 !== 16'd0) begin failures++; $display("FAIL flush_mcu_cnt got=%0d exp=0", mcu_cnt); end
    endtask

    task automatic test_random_ready();
        logic [11:0] exp_q[$];
        int n_y, n_cb, n_cr;
        int cyc;
        do_reset();
        cfg_ny = 3'd2; cfg_gray = 1'b0;
        fill(128, 64, 64);
        for (int i = 0; i < 128; i++) exp_q.push_back(12'(i));
        for (int i = 0; i < 64; i++)  exp_q.push_back(12'(12'h400 + i));
        for (int i = 0; i < 64; i++)  exp_q.push_back(12'(12'h800 + i));
        n_y = 0; n_cb = 0; n_cr = 0; cyc = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_y += int'(y_rd); n_cb += int'(cb_rd); n_cr += int'(cr_rd);
            if (!out_ready) begin
                checks++; if ({y_rd, cb_rd, cr_rd} !== 3'b000) begin failures++; $display("FAIL rand_rd_no_ready cyc=%0d got=%b exp=000", cyc, {y_rd, cb_rd, cr_rd}); end
            end else if (out_valid) begin
                checks++; if (out_data !== exp_q[0]) begin failures++; $display("FAIL rand_order cyc=%0d got=%h exp=%h", cyc, out_data, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_timeout remaining=%0d exp=0", exp_q.size()); end
        @(negedge clk);
        checks++; if (n_y != 128 || n_cb != 64 || n_cr != 64) begin failures++; $display("FAIL rand_rd_counts got=%0d/%0d/%0d exp=128/64/64", n_y, n_cb, n_cr); end
        checks++; if (mcu_cnt !== 16'd1) begin failures++; $display("FAIL rand_mcu_cnt got=%0d exp=1", mcu_cnt); end
    endtask

    initial begin
        test_reset();
        test_mcu_sequence(3'd4, 1'b0, 4);
        test_mcu_sequence(3'd0, 1'b0, 1);
        test_mcu_sequence(3'd7, 1'b1, 4);
        test_gray_cfg_latch();
        test_cb_stall();
        test_flush();
        test_random_ready();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcu_fifo_sched.md
# mcu_fifo_sched

Scheduler that drains the three per-component coefficient FIFOs (Y, Cb, Cr; `fifo_sync` instances in SHOWAHEAD mode) into one stream in MCU order. Each MCU is NY Y blocks, then one Cb block, then one Cr block, or NY Y blocks only in grayscale mode. The block sits between the entropy/dequant stage, which fills the FIFOs, and the IDCT, which consumes the merged stream through a valid/ready handshake. It generates the FIFO `rd` strobes and tags each sample with its component, block-end and MCU-end markers.

## Interface
- `DW`, default 12: coefficient width.
- `BLK_LEN`, default 64: samples per block. Must be a power of two, at least 2.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `cfg_ny`  in  3: Y blocks per MCU. 0 is treated as 1; values above 4 are treated as 4.
- `cfg_gray`  in  1: 1 = Y-only MCUs.
- `flush`  in  1: synchronous abort of the current MCU.
- `y_empty`, `cb_empty`, `cr_empty`  in  1 each: FIFO empty flags.
- `y_dout`, `cb_dout`, `cr_dout`  in  DW each: show-ahead FIFO heads.
- `y_rd`, `cb_rd`, `cr_rd`  out  1 each: FIFO pop strobes.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: downstream accepts the sample.
- `out_data`  out  DW: coefficient.
- `out_comp`  out  2: component tag. 0 = Y, 1 = Cb, 2 = Cr.
- `out_blk_last`  out  1: last sample of a block.
- `out_mcu_last`  out  1: last sample of an MCU.
- `mcu_cnt`  out  16: number of completed MCUs, wraps at 65535 to 0.

## Operation
- State machine states: S_Y, S_CB, S_CR. The current state selects the source FIFO and `out_comp`.
- Counters:
  - `smp`: log2(BLK_LEN) bits, 0..BLK_LEN-1.
  - `blk`: 2 bits, Y block index.
- The source is the FIFO selected by the state. `out_valid` = !source_empty & !flush. `out_data` = source_dout.
- Transfer condition `xfer` = `out_valid` & `out_ready`. The `rd` of the source FIFO equals `xfer`. The other two `rd` outputs are 0.
- On each `xfer`, `smp` increments. When `smp` = BLK_LEN-1 it wraps to 0 and `out_blk_last` = 1 for that sample.
- Block-end transitions:
  - S_Y: if `blk` = NY-1, clear `blk` and go to S_CB, or to S_Y if gray. Otherwise increment `blk`.
  - S_CB: go to S_CR.
  - S_CR: go to S_Y.
- `out_mcu_last` = `out_blk_last` on the last block of an MCU: the Cr block, or Y block NY-1 when gray. `mcu_cnt` increments on that transfer.
- MCU config latching:
  - While in the MCU-start position (S_Y, `blk` = 0, `smp` = 0), the effective NY and gray values come combinationally from `cfg_ny` and `cfg_gray`, with the clamp rules applied.
  - Both values are latched into `ny_r` and `gray_r` on the first `xfer` of the MCU. For the rest of the MCU, `cfg_*` changes are ignored.
- `flush` has priority over everything:
  - Blocks `xfer`, so no `rd` and no `out_valid` in that cycle.
  - On the next edge, returns the machine to S_Y with `smp` and `blk` cleared. `mcu_cnt` is unchanged.
  - FIFO contents are not touched.
- Reset values: state S_Y; `smp`, `blk` and `mcu_cnt` = 0; `ny_r` = 1; `gray_r` = 0.
- Outputs during reset: all `rd` strobes are 0, `out_valid` = 0, `out_comp` = 0, `out_blk_last` = 0, `out_mcu_last` = 0.

## Timing
- Zero-latency forwarding: `out_valid`, `out_data`, the tags and the `rd` strobes are combinational from the current state and the FIFO and handshake inputs.
- State, counters and `mcu_cnt` update on the `clk` edge that ends a transfer cycle.
- Full throughput is one sample per cycle while the source is non-empty and `out_ready` is held high. There is no bubble at block or component switches.
- Stall behaviour:
  - With `out_ready` = 0, the outputs hold and no `rd` is issued.
  - An empty source FIFO stalls the stream even if other FIFOs hold data. The scheduler never skips ahead or reorders.
- `out_ready` may change in any cycle. `out_valid` does not depend on `out_ready`.
- Reset asserts asynchronously and clears state immediately. Reset released mid-block discards that block position; the upstream FIFOs are reset by the same `rst`.

## Test plan
- NY=4, not gray, BLK_LEN=64, all FIFOs pre-filled, `out_ready`=1 → 384 consecutive transfers.
  - `out_comp` sequence: 256×0, 64×1, 64×2.
  - `out_blk_last` at transfers 63, 127, …, 383.
  - `out_mcu_last` only at 383.
  - `mcu_cnt` = 1.
- `cfg_gray`=1, NY=2 → MCU of 128 Y samples, `out_mcu_last` at 127, `cb_rd`/`cr_rd` never asserted. Changing `cfg_ny` to 4 mid-MCU gives no effect until the next MCU.
- `cb_empty`=1 while Y data is plentiful → after the Y blocks, `out_valid`=0 with no `y_rd`. Writing one Cb sample produces exactly one transfer tagged `out_comp`=1.
- Random `out_ready` toggling with 50% duty → the output sample order equals the FIFO write order, with no drops or duplicates, and each `rd` count equals its write count.
- `flush` asserted at sample 10 of Cb block → no transfer that cycle. The next transfer is tagged Y with `smp`=0, and `mcu_cnt` is unchanged.
- `cfg_ny`=0 gives 1 Y block per MCU, `cfg_ny`=7 gives 4. Run 65536 MCUs with BLK_LEN=2 → `mcu_cnt` wraps to 0.
